// File: rtl/multdiv_pkg.sv
// Shared definitions for mult_div_unit: FSM state encoding, default sizing and sign helper.
// The divide path is present only when MULTDIV_DIV_EN is defined.
package multdiv_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned ITER_DEF  = WIDTH_DEF;
  localparam int unsigned MAXW      = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE
  } state_e;

  // Two's-complement negate when neg is set; callers zero-extend to MAXW and truncate.
  function automatic logic [MAXW-1:0] sign_fix(input logic [MAXW-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// div_restore_core: restoring division on operand magnitudes, one quotient bit per step.
// Instantiated by mult_div_unit only when MULTDIV_DIV_EN is defined.
module div_restore_core
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvs_q});
    if (load_i) begin
      rem_d = '0;
      quo_d = WIDTH'(sign_fix(MAXW'(dividend_i), dividend_i[WIDTH-1]));
      dvs_d = WIDTH'(sign_fix(MAXW'(divisor_i), divisor_i[WIDTH-1]));
    end else if (step_i) begin
      rem_d = ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ge};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed Booth multiply / restoring divide into HI/LO.
// Define MULTDIV_DIV_EN to build the divide path; otherwise start_div is ignored.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ITER = WIDTH;
  localparam int unsigned CW   = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d, mcand_q, mcand_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   m_ext, booth_sum, acc_n;
  logic [WIDTH-1:0] mq_n;

`ifdef MULTDIV_DIV_EN
  logic             dz_q, dz_d, dzp_q, dzp_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             div_load, div_step;
  logic [WIDTH-1:0] quo_mag, rem_mag;

  div_restore_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load_i    (div_load),
    .step_i    (div_step),
    .dividend_i(op_a),
    .divisor_i (op_b),
    .quo_o     (quo_mag),
    .rem_o     (rem_mag)
  );

  assign div_zero = dz_q;
`else
  logic unused_start_div;
  assign unused_start_div = start_div;
  assign div_zero         = 1'b0;
`endif

  // Accumulator is one bit wider so adding/subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    m_ext = {mcand_q[WIDTH-1], mcand_q};
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mq_n  = {booth_sum[0], mq_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
`ifdef MULTDIV_DIV_EN
    dz_d     = dz_q;
    dzp_d    = dzp_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div_load = 1'b0;
    div_step = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          state_d = S_MULT;
          cnt_d   = '0;
          acc_d   = '0;
          mq_d    = op_b;
          qm1_d   = 1'b0;
          mcand_d = op_a;
`ifdef MULTDIV_DIV_EN
          dz_d    = 1'b0;
        end else if (start_div) begin
          state_d  = S_DIV;
          cnt_d    = '0;
          dz_d     = 1'b0;
          dzp_d    = (op_b == '0);
          qneg_d   = op_a[WIDTH-1] ^ op_b[WIDTH-1];
          rneg_d   = op_a[WIDTH-1];
          div_load = 1'b1;
`endif
        end
      end
      S_MULT: begin
        acc_d = acc_n;
        mq_d  = mq_n;
        qm1_d = mq_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = S_DONE;
          hi_d    = acc_n[WIDTH-1:0];
          lo_d    = mq_n;
        end
      end
`ifdef MULTDIV_DIV_EN
      S_DIV: begin
        if (dzp_q) begin
          state_d = S_DONE;
          dz_d    = 1'b1;
        end else if (cnt_q == CW'(ITER)) begin
          state_d = S_DONE;
          lo_d    = WIDTH'(sign_fix(MAXW'(quo_mag), qneg_q));
          hi_d    = WIDTH'(sign_fix(MAXW'(rem_mag), rneg_q));
        end else begin
          div_step = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
`ifdef MULTDIV_DIV_EN
      dz_q    <= 1'b0;
      dzp_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
`ifdef MULTDIV_DIV_EN
      dz_q    <= dz_d;
      dzp_q   <= dzp_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, corner sequences and randomized
// operands against an arithmetic reference model. Divide checks need MULTDIV_DIV_EN.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_mult(start_mult),
    .start_div (start_div),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mul;
    bit          dv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    bit          edz;
    int          lat;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic; divide by zero leaves HI/LO as they were.
  function automatic vec_t model(input bit dv, input logic [31:0] a, input logic [31:0] b);
    vec_t        v;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    v.mul = !dv;
    v.dv  = dv;
    v.a   = a;
    v.b   = b;
    v.edz = 1'b0;
    if (!dv) begin
      p     = sa * sb;
      v.eh  = p[63:32];
      v.el  = p[31:0];
      v.lat = 32;
    end else if (b == 32'd0) begin
      v.eh  = m_hi;
      v.el  = m_lo;
      v.edz = 1'b1;
      v.lat = 1;
    end else begin
      p     = sa / sb;
      v.el  = p[31:0];
      p     = sa % sb;
      v.eh  = p[31:0];
      v.lat = 33;
    end
    return v;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one start strobe, then count edges after the accepting edge until done.
  task automatic run_op(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b,
                        input int div_pulse_at, output int lat, output int busy_low,
                        output int chg);
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          n;
    @(negedge clk);
    start_mult = mul;
    start_div  = dv;
    op_a       = a;
    op_b       = b;
    pre_hi     = hi;
    pre_lo     = lo;
    @(posedge clk);
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
    n          = 0;
    busy_low   = 0;
    chg        = 0;
    while (!done && n < 100) begin
      if (!busy) busy_low++;
      if (hi !== pre_hi || lo !== pre_lo) chg++;
      start_div = (div_pulse_at != 0 && n == div_pulse_at - 1);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start_div = 1'b0;
    lat       = n;
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int lat;
    int bl;
    int chg;
    run_op(v.mul, v.dv, v.a, v.b, 0, lat, bl, chg);
    chk({tag, " latency"}, 64'(lat), 64'(v.lat));
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, v.eh});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, v.el});
    chk({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, v.edz});
    chk({tag, " busy_at_done"}, {63'd0, busy}, 64'd1);
    chk({tag, " busy_low_cycles"}, 64'(bl), 64'd0);
    chk({tag, " early_hilo_change"}, 64'(chg), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, " idle_done"}, {63'd0, done}, 64'd0);
    chk({tag, " idle_div_zero"}, {63'd0, div_zero}, {63'd0, v.edz});
    m_hi = v.eh;
    m_lo = v.el;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   bl;
    int   chg;
    vec_t v;

    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = '0;
    op_b       = '0;

    tbl.push_back('{1'b1, 1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32});
    tbl.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 32});
    tbl.push_back('{1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 32});
    tbl.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 32});
`ifdef MULTDIV_DIV_EN
    tbl.push_back('{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33});
    tbl.push_back('{1'b0, 1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1});
    tbl.push_back('{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33});
    tbl.push_back('{1'b0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 33});
    tbl.push_back('{1'b0, 1'b1, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 33});
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset div_zero", {63'd0, div_zero}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply_vec($sformatf("vec%0d", i), tbl[i]);

`ifndef MULTDIV_DIV_EN
    // Without the divider, start_div alone must leave the unit idle and HI/LO untouched.
    @(negedge clk);
    start_div = 1'b1;
    op_a      = 32'd5;
    op_b      = 32'd1;
    @(posedge clk);
    @(negedge clk);
    start_div = 1'b0;
    chk("nodiv busy", {63'd0, busy}, 64'd0);
    chk("nodiv div_zero", {63'd0, div_zero}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("nodiv busy_later", {63'd0, busy}, 64'd0);
    chk("nodiv hi", {32'd0, hi}, {32'd0, m_hi});
    chk("nodiv lo", {32'd0, lo}, {32'd0, m_lo});
`endif

    // Both strobes together: multiply wins; a start_div sampled at E5 is ignored.
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 5, lat, bl, chg);
    chk("both latency", 64'(lat), 64'd32);
    chk("both lo", {32'd0, lo}, 64'd12);
    chk("both hi", {32'd0, hi}, 64'd0);
    chk("both busy_low_cycles", 64'(bl), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("both idle_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("both no_late_div", {63'd0, busy}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd12;

    // Reset sampled at E10 of a multiply discards it and clears HI/LO.
    @(negedge clk);
    start_mult = 1'b1;
    op_a       = 32'h1234_5678;
    op_b       = 32'h0000_0100;
    @(posedge clk);
    @(negedge clk);
    start_mult = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("midop busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy", {63'd0, busy}, 64'd0);
    chk("midrst done", {63'd0, done}, 64'd0);
    chk("midrst hi", {32'd0, hi}, 64'd0);
    chk("midrst lo", {32'd0, lo}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst stays_idle", {63'd0, busy}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    apply_vec("post_reset_mult", model(1'b0, 32'd2, 32'd3));

    for (int i = 0; i < 16; i++) begin
      v = model(1'b0, pick(), pick());
      apply_vec($sformatf("rand_mult%0d", i), v);
    end
`ifdef MULTDIV_DIV_EN
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      v = model(1'b1, a, b);
      apply_vec($sformatf("rand_div%0d", i), v);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
